// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl
//
// Fetch-side PC sequencer for the RISC-V core. It owns the architectural PC,
// drives the instruction-memory request handshake, and picks the next PC from
// four sources: sequential (PC+4), PC-relative branch (PC+IMMEXT), JALR target,
// or the trap vector. It also covers the boot delay after reset, imem wait
// states, core stalls, latched external traps and misaligned redirect targets.
//
// Parameters:
//   RESET_PC     PC value loaded on reset
//   BOOT_CYCLES  cycles spent in BOOT after reset release (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   PC           address of the current instruction (registered)
//   IMEM_ADDR    fetch address, always equal to PC
//   IMEM_REQ     fetch request, high only while fetching
//   IMEM_RDY     imem has valid data for IMEM_ADDR this cycle
//   STALL        core back-pressure; the instruction must not retire
//   INSTR_VALID  instruction at PC retires this cycle
//   PCSrc        00 sequential, 01 PC+IMMEXT, 10 JALR_TARGET, 11 as 00
//   IMMEXT       sign-extended branch/JAL offset
//   JALR_TARGET  rs1+imm from the ALU
//   TRAP_REQ     external trap/interrupt pulse
//   MTVEC        trap vector base
//   EPC          PC saved on trap entry
//   TRAP_TAKEN   one-cycle pulse, trap entry this cycle
//   MISALIGN     one-cycle pulse, redirect target misaligned
// -----------------------------------------------------------------------------
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic        IMEM_RDY,
  input  logic        STALL,
  output logic        INSTR_VALID,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] IMMEXT,
  input  logic [31:0] JALR_TARGET,
  input  logic        TRAP_REQ,
  input  logic [31:0] MTVEC,
  output logic [31:0] EPC,
  output logic        TRAP_TAKEN,
  output logic        MISALIGN
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01
  } state_t;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JALR   = 2'b10,
    SRC_ALTSEQ = 2'b11
  } pc_src_t;

  // Last boot-counter value before moving to FETCH; BOOT lasts BOOT_CYCLES
  // cycles counting 0..BOOT_CYCLES-1.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state;
  logic [3:0]  boot_cnt;
  logic        trap_pending;
  logic        req_q;

  logic        boundary;
  logic        trap_entry;
  logic        retire;
  logic        target_misaligned;
  logic [31:0] target;
  logic [31:0] trap_vector;

  // ---------------------------------------------------------------------------
  // Combinational decode of the current cycle
  // ---------------------------------------------------------------------------

  // An instruction boundary: imem has data and the core accepts it. Reset in
  // the same cycle abandons the fetch, so nothing is allowed to retire.
  assign boundary   = (state == ST_FETCH) && IMEM_RDY && !STALL && !rst;

  // A latched trap wins over everything else at a boundary and suppresses
  // retirement of the instruction at PC.
  assign trap_entry = boundary && trap_pending;
  assign retire     = boundary && !trap_pending;

  // Trap vector is always word aligned regardless of MTVEC[1:0].
  assign trap_vector = MTVEC & ~32'h0000_0003;

  // NOTE: every signal assigned in an always_comb gets a default on entry so a
  // path that forgets to assign it cannot turn into an inferred latch.
  always_comb begin
    target = PC + 32'd4;
    unique case (pc_src_t'(PCSrc))
      SRC_BRANCH: target = PC + IMMEXT;
      SRC_JALR:   target = JALR_TARGET & ~32'h0000_0001;
      SRC_SEQ,
      SRC_ALTSEQ: target = PC + 32'd4;
      default:    target = PC + 32'd4;
    endcase
  end

  // JALR clears bit 0 only, so bit 1 can still make the target misaligned;
  // a branch with an odd or half-word offset can set either bit.
  assign target_misaligned = (target[1:0] != 2'b00);

  assign INSTR_VALID = retire;
  assign MISALIGN    = retire && target_misaligned;
  assign TRAP_TAKEN  = trap_entry || MISALIGN;

  // The request flop tracks the FETCH state; it is masked during a reset cycle
  // so an in-flight request is dropped immediately.
  assign IMEM_REQ  = req_q && !rst;
  assign IMEM_ADDR = PC;

  // ---------------------------------------------------------------------------
  // Sequential state: FSM, PC, EPC and the trap latch
  // ---------------------------------------------------------------------------

  // NOTE: all registers here use non-blocking assignments so every branch reads
  // the pre-edge values of PC, state and trap_pending, exactly like hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BOOT;
      boot_cnt     <= 4'd0;
      req_q        <= 1'b0;
      PC           <= RESET_PC;
      EPC          <= 32'h0000_0000;
      trap_pending <= 1'b0;
    end else begin
      // Trap latch: set by any pulse, cleared only by a trap-pending entry.
      // A pulse arriving in the entry cycle itself is absorbed by that entry,
      // and repeated pulses before entry collapse into one.
      if (trap_entry) begin
        trap_pending <= 1'b0;
      end else if (TRAP_REQ) begin
        trap_pending <= 1'b1;
      end

      case (state)
        ST_BOOT: begin
          req_q <= 1'b0;
          if (boot_cnt == BOOT_LAST) begin
            state <= ST_FETCH;
            req_q <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 4'd1;
          end
        end

        ST_FETCH: begin
          req_q <= 1'b1;
          // Wait states and stalls fall through with PC and EPC unchanged.
          if (TRAP_TAKEN) begin
            // Covers both a latched external trap and a misaligned redirect;
            // in the latter case EPC records the faulting jump itself.
            EPC <= PC;
            PC  <= trap_vector;
          end else if (retire) begin
            PC  <= target;
          end
        end

        default: begin
          // Unreachable encodings restart the boot sequence.
          state    <= ST_BOOT;
          boot_cnt <= 4'd0;
          req_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Fetch-side PC sequencer for the RISC-V core.
- Owns the architectural PC register, drives the instruction-memory request handshake, and chooses the next PC from four sources: sequential, PC-relative branch, JALR target, or trap vector.
- Handles boot delay, fetch wait states, core stalls, pending external traps and misaligned redirect targets.
- Sits between the imem port and the single-cycle decode/execute datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BOOT_CYCLES, 2, cycles held in BOOT after reset release (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
PC  output  32  address of the current instruction (registered)
IMEM_ADDR  output  32  fetch address, always equal to PC
IMEM_REQ  output  1  fetch request, high only in FETCH
IMEM_RDY  input  1  imem has valid data for IMEM_ADDR this cycle
STALL  input  1  core back-pressure; instruction must not retire
INSTR_VALID  output  1  instruction at PC retires this cycle
PCSrc  input  2  00 sequential, 01 PC+IMMEXT, 10 JALR_TARGET, 11 treated as 00
IMMEXT  input  32  sign-extended branch/JAL offset
JALR_TARGET  input  32  rs1+imm from ALU
TRAP_REQ  input  1  external trap/interrupt pulse
MTVEC  input  32  trap vector base
EPC  output  32  PC saved on trap entry
TRAP_TAKEN  output  1  one-cycle pulse, trap entry this cycle
MISALIGN  output  1  one-cycle pulse, redirect target misaligned

Behaviour:
- Reset (rst=1 at a clock edge):
  - PC=RESET_PC, EPC=0, state=BOOT, boot counter=0, trap_pending=0.
  - All pulse outputs are 0; IMEM_REQ=0.
  - Reset mid-fetch abandons the request with no retirement.
- BOOT:
  - IMEM_REQ=0; counter increments each cycle.
  - Go to FETCH after exactly BOOT_CYCLES cycles. IMEM_REQ rises in cycle BOOT_CYCLES+1 after reset deassertion.
- FETCH:
  - IMEM_REQ=1; IMEM_ADDR=PC combinationally.
  - A cycle is a "boundary" when IMEM_RDY=1 and STALL=0.
  - IMEM_RDY=0, or STALL=1: PC holds, INSTR_VALID=0, PCSrc/IMMEXT/JALR_TARGET are ignored.
- Trap latch:
  - TRAP_REQ=1 in any non-reset cycle sets trap_pending.
  - trap_pending stays set until trap entry, including across wait/stall cycles. Multiple pulses collapse to one.
- Boundary with trap_pending=1 (highest priority):
  - INSTR_VALID=0, so the instruction is not retired.
  - EPC<=PC, PC<=MTVEC with bits[1:0] forced to 00.
  - TRAP_TAKEN=1; trap_pending cleared.
  - A TRAP_REQ in this same cycle is consumed by this entry, not re-latched.
- Boundary with no trap pending: INSTR_VALID=1 and the target is computed as:
  - 00/11: PC+4
  - 01: PC+IMMEXT
  - 10: {JALR_TARGET[31:1],1'b0}
  - All adds are 32-bit, modulo 2^32; wrap from 32'hFFFF_FFFC+4 gives 0.
- Misaligned target (target[1:0]!=00) on a boundary:
  - Instruction still retires (INSTR_VALID=1).
  - PC<=MTVEC with bits[1:0] forced to 00; EPC<=PC (the faulting jump).
  - MISALIGN=1 and TRAP_TAKEN=1 in the same cycle.
- Otherwise PC<=target.
- Combinational timing: INSTR_VALID, TRAP_TAKEN and MISALIGN are functions of the current state and inputs. EPC and PC update on the following edge.
- No other states exist. Illegal state encodings recover to BOOT.

Test Plan:
- BOOT_CYCLES=2, RESET_PC=0x100, reset 1 cycle, IMEM_RDY=1 -> IMEM_REQ=0 for 2 cycles, then PC sequence 0x100, 0x104, 0x108 with INSTR_VALID=1 each cycle.
- IMEM_RDY low 3 cycles at PC=0x104 then high -> PC holds 0x104 and INSTR_VALID=0 for 3 cycles; next PC 0x108. STALL=1 for 2 cycles gives the same hold.
- At PC=0x200: PCSrc=01, IMMEXT=0xFFFF_FFF0 -> next PC 0x1F0. PCSrc=10, JALR_TARGET=0x301 -> next PC 0x300, no MISALIGN.
- MTVEC=0x80; PCSrc=01, IMMEXT=0x6 at PC=0x200 -> MISALIGN=1, TRAP_TAKEN=1, EPC=0x200, next PC 0x80.
- TRAP_REQ pulse while IMEM_RDY=0 at PC=0x104, with PCSrc=01 on the next boundary -> INSTR_VALID=0, TRAP_TAKEN=1, EPC=0x104, next PC=MTVEC; branch ignored.
- Reset asserted during a wait state with trap_pending=1 -> PC=RESET_PC, trap cleared, no TRAP_TAKEN after BOOT.
